axis_fifo_arbiter: RTL and testbench
====================================

AXIS_FIFO_ARBITER -- requirements
Module: axis_fifo_arbiter

Interface
REQ-001 Parameter PORTS, default 4, is the number of AXI-stream requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, is the tdata width per port.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 async_rst  input  1  asynchronous, active-high reset.
REQ-005 input_axis_tdata  input  PORTS*DATA_WIDTH  per-port data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 input_axis_tvalid / input_axis_tlast / input_axis_tuser  input  PORTS each  per-port valid, end-of-packet and user flag.
REQ-007 input_axis_tready  output  PORTS  per-port ready.
REQ-008 output_axis_tdata  output  DATA_WIDTH; output_axis_tvalid, output_axis_tlast, output_axis_tuser  output  1 each; these drive the shared FIFO input.
REQ-009 output_axis_tready  input  1  ready from the shared FIFO.
REQ-010 grant_index  output  clog2(PORTS)  currently or last granted port.
REQ-011 busy  output  1  high while in state PASS.

Function
REQ-012 The FSM SHALL have two states: IDLE and PASS.
REQ-013 In IDLE, every input_axis_tready bit and output_axis_tvalid SHALL be 0.
REQ-014 In IDLE, if any input_axis_tvalid bit is 1, the block SHALL select the first requesting port searching upward from (last grant + 1) mod PORTS, register it in grant_index and enter PASS on the next edge.
REQ-015 In IDLE with no requests, the state and grant_index SHALL hold.
REQ-016 In PASS, output_axis_tdata/tvalid/tlast/tuser SHALL equal the granted port's inputs combinationally.
REQ-017 In PASS, input_axis_tready SHALL equal output_axis_tready for the granted port and SHALL be 0 for all others.
REQ-018 A beat transfers when output_axis_tvalid and output_axis_tready are both 1 on a clock edge.
REQ-019 The grant SHALL change only after a transferred beat with tlast=1, which returns the FSM to IDLE; packets are never interleaved.
REQ-020 A granted port that drops tvalid mid-packet SHALL keep the grant indefinitely; output_axis_tvalid follows the port (0).
REQ-021 Arbitration costs exactly one bubble cycle per packet, so a single-beat packet occupies two cycles minimum.
REQ-022 Round-robin wrap: after port PORTS-1, the search SHALL continue at port 0.
REQ-023 Requests arriving on non-granted ports while in PASS SHALL be stalled (tready 0), not dropped.

Reset
REQ-024 While async_rst=1, the block SHALL be in IDLE, grant_index SHALL be PORTS-1 (so port 0 wins first), busy SHALL be 0, and all tready and output_axis_tvalid SHALL be 0 independently of the clock.
REQ-025 No input beat SHALL be accepted while async_rst=1; reset asserted mid-packet SHALL abandon the packet, and the first cycle after deassertion SHALL be IDLE.

Configuration
REQ-026 Macro AXIS_ARB_PKT_CNT_EN: when defined, the block SHALL add output pkt_count (PORTS*16 bits), one 16-bit counter per port that increments on each transferred tlast beat of that port, wraps from 65535 to 0, and resets to 0.
REQ-027 When AXIS_ARB_PKT_CNT_EN is undefined, the pkt_count port and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package axis_arb_pkg SHALL hold the FSM state encoding (IDLE=0, PASS=1) and the counter width constant 16.
REQ-029 The rotating priority search SHALL be the sub-module rr_select (inputs: request vector, last grant; outputs: valid, index), which is combinational.
REQ-030 The top SHALL instantiate only rr_select and SHALL contain the FSM, the muxes and the optional counters.

Verification
REQ-031 Hold async_rst=1 for 5 cycles with port 0 tvalid=1 and tdata=0x03 -> tready stays 0, output tvalid stays 0 and nothing is written to the FIFO.
REQ-032 After reset, ports 0 and 2 each present a 1-beat packet (0x11, 0x22) simultaneously -> output carries 0x11 then 0x22, each packet follows an IDLE bubble, and grant_index reads 0 then 2.
REQ-033 Port 1 sends a 3-beat packet 0xA0..0xA2 while port 3 requests -> port 3 gets no tready until the 0xA2 tlast beat transfers, and the output order is A0,A1,A2, then port 3's data.
REQ-034 With output_axis_tready toggled 1,0,1,0 during a 4-beat packet -> every beat is delivered exactly once and in order, with input tready mirroring output tready.
REQ-035 All 4 ports request continuously with 1-beat packets -> the grant sequence is 0,1,2,3,0; with AXIS_ARB_PKT_CNT_EN defined, each pkt_count equals 1 after the first four packets (port 0 equals 2 after the fifth).
REQ-036 async_rst is asserted for 1 cycle after beat 2 of a 4-beat packet -> the remaining beats are not forwarded until a new grant occurs, and the next grant goes to port 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-stream FIFO arbiter: FSM state encoding
// and the width of the optional per-port packet counters.
package axis_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } arb_state_t;

    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority request selector. Searches upward from (last + 1)
// modulo PORTS and returns the first asserted request. Purely combinational.
module rr_select
    import axis_arb_pkg::*;
#(
    parameter int PORTS = 4,
    localparam int IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_index
);

    // Walk candidates from farthest to nearest so the nearest requester
    // after the last grant is the one left standing.
    always_comb begin
        int              w_cand;
        logic [IDX_W-1:0] w_idx;
        o_valid = 1'b0;
        o_index = i_last;
        w_cand  = 0;
        w_idx   = '0;
        for (int k = PORTS; k >= 1; k--) begin
            w_cand = int'(i_last) + k;
            if (w_cand >= PORTS) begin
                w_cand = w_cand - PORTS;
            end
            w_idx = IDX_W'(w_cand);
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_index = w_idx;
            end
        end
    end

endmodule

// File: rtl/axis_fifo_arbiter.sv
// Round-robin arbiter funnelling PORTS AXI-stream sources into one shared
// FIFO input. Whole packets are passed without interleaving; each packet
// costs one IDLE arbitration cycle.
// Optional feature: define AXIS_ARB_PKT_CNT_EN to add pkt_count, one 16-bit
// wrapping counter of completed packets per port.
module axis_fifo_arbiter
    import axis_arb_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        async_rst,
    input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
    input  logic [PORTS-1:0]            input_axis_tvalid,
    input  logic [PORTS-1:0]            input_axis_tlast,
    input  logic [PORTS-1:0]            input_axis_tuser,
    output logic [PORTS-1:0]            input_axis_tready,
    output logic [DATA_WIDTH-1:0]       output_axis_tdata,
    output logic                        output_axis_tvalid,
    output logic                        output_axis_tlast,
    output logic                        output_axis_tuser,
    input  logic                        output_axis_tready,
    output logic [$clog2(PORTS)-1:0]    grant_index,
    output logic                        busy
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    output logic [PORTS*PKT_CNT_W-1:0]  pkt_count
`endif
);

    localparam int IDX_W = $clog2(PORTS);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_grant_next;
    logic             w_sel_valid;
    logic [IDX_W-1:0] w_sel_index;
    logic             w_xfer_last;

    rr_select #(
        .PORTS (PORTS)
    ) u_rr_select (
        .i_req   (input_axis_tvalid),
        .i_last  (r_grant),
        .o_valid (w_sel_valid),
        .o_index (w_sel_index)
    );

    // Final beat of the granted packet is accepted by the FIFO this cycle.
    assign w_xfer_last = (r_state == ST_PASS) & input_axis_tvalid[r_grant]
                       & output_axis_tready & input_axis_tlast[r_grant];

    assign grant_index = r_grant;

    // State and grant registers; reset parks the grant on the top port so
    // port 0 is first in line.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_state <= ST_IDLE;
            r_grant <= IDX_W'(PORTS - 1);
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
        end
    end

    // Next-state logic plus the data/handshake muxes toward the FIFO.
    always_comb begin
        w_state_next       = r_state;
        w_grant_next       = r_grant;
        input_axis_tready  = '0;
        output_axis_tdata  = input_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
        output_axis_tvalid = 1'b0;
        output_axis_tlast  = 1'b0;
        output_axis_tuser  = 1'b0;
        busy               = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_state_next = ST_PASS;
                    w_grant_next = w_sel_index;
                end
            end
            ST_PASS: begin
                busy                       = 1'b1;
                output_axis_tvalid         = input_axis_tvalid[r_grant];
                output_axis_tlast          = input_axis_tlast[r_grant];
                output_axis_tuser          = input_axis_tuser[r_grant];
                input_axis_tready[r_grant] = output_axis_tready;
                if (w_xfer_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [PORTS*PKT_CNT_W-1:0] r_pkt_cnt;

    // Count completed packets per port; 16-bit counters wrap naturally.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (w_xfer_last && (r_grant == IDX_W'(i))) begin
                    r_pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] <=
                        r_pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] + 1'b1;
                end
            end
        end
    end

    assign pkt_count = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Self-checking bench for axis_fifo_arbiter (PORTS=4, DATA_WIDTH=8):
// directed vector table, a continuous-request round-robin sequence, and a
// randomized run against a packet-level reference model.
module tb_axis_fifo_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 8;

    logic                  clk = 1'b0;
    logic                  async_rst;
    logic [PORTS*DW-1:0]   in_tdata;
    logic [PORTS-1:0]      in_tvalid;
    logic [PORTS-1:0]      in_tlast;
    logic [PORTS-1:0]      in_tuser;
    logic [PORTS-1:0]      in_tready;
    logic [DW-1:0]         out_tdata;
    logic                  out_tvalid;
    logic                  out_tlast;
    logic                  out_tuser;
    logic                  out_tready;
    logic [1:0]            grant_index;
    logic                  busy;
`ifdef AXIS_ARB_PKT_CNT_EN
    logic [PORTS*16-1:0]   pkt_count;
`endif

    int checks = 0;
    int errors = 0;

    axis_fifo_arbiter #(
        .PORTS      (PORTS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .async_rst          (async_rst),
        .input_axis_tdata   (in_tdata),
        .input_axis_tvalid  (in_tvalid),
        .input_axis_tlast   (in_tlast),
        .input_axis_tuser   (in_tuser),
        .input_axis_tready  (in_tready),
        .output_axis_tdata  (out_tdata),
        .output_axis_tvalid (out_tvalid),
        .output_axis_tlast  (out_tlast),
        .output_axis_tuser  (out_tuser),
        .output_axis_tready (out_tready),
        .grant_index        (grant_index),
`ifdef AXIS_ARB_PKT_CNT_EN
        .pkt_count          (pkt_count),
`endif
        .busy               (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] l;
        logic [31:0] d;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ol;
        logic [3:0] rdy;
        logic [1:0] g;
        logic       bsy;
    } vec_t;

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                                logic ordy, logic ov, logic [7:0] od, logic ol,
                                logic [3:0] rdy, logic [1:0] g, logic bsy);
        vec_t r;
        r.rst = rst; r.v = v; r.l = l; r.d = d; r.ordy = ordy;
        r.ov = ov; r.od = od; r.ol = ol; r.rdy = rdy; r.g = g; r.bsy = bsy;
        return r;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t q[PORTS][$];

    task automatic do_reset();
        in_tvalid  = '0;
        in_tlast   = '0;
        in_tuser   = '0;
        in_tdata   = '0;
        out_tready = 1'b1;
        async_rst  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        async_rst = 1'b0;
    endtask

    task automatic run_table();
        vec_t tbl[$];
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 4'b0001, 4'b0001, 32'h00000003, 1, 0, 8'h00, 0, 4'b0000, 2'd3, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 32'h00220011, 1, 0, 8'h00, 0, 4'b0000, 2'd3, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 32'h00220011, 1, 1, 8'h11, 1, 4'b0001, 2'd0, 1));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 32'h00220000, 1, 0, 8'h00, 0, 4'b0000, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 32'h00220000, 1, 1, 8'h22, 1, 4'b0100, 2'd2, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000A000, 1, 0, 8'h00, 0, 4'b0000, 2'd2, 0));
        tbl.push_back(mk(0, 4'b1010, 4'b1000, 32'h3300A000, 1, 1, 8'hA0, 0, 4'b0010, 2'd1, 1));
        tbl.push_back(mk(0, 4'b1010, 4'b1000, 32'h3300A100, 1, 1, 8'hA1, 0, 4'b0010, 2'd1, 1));
        tbl.push_back(mk(0, 4'b1010, 4'b1010, 32'h3300A200, 1, 1, 8'hA2, 1, 4'b0010, 2'd1, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 32'h33000000, 1, 0, 8'h00, 0, 4'b0000, 2'd1, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 32'h33000000, 1, 1, 8'h33, 1, 4'b1000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000B000, 1, 0, 8'h00, 0, 4'b0000, 2'd3, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000B000, 1, 1, 8'hB0, 0, 4'b0010, 2'd1, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000B100, 1, 1, 8'hB1, 0, 4'b0010, 2'd1, 1));
        tbl.push_back(mk(1, 4'b0011, 4'b0001, 32'h0000B20F, 1, 0, 8'h00, 0, 4'b0000, 2'd3, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0001, 32'h0000B20F, 1, 0, 8'h00, 0, 4'b0000, 2'd3, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0001, 32'h0000B20F, 1, 1, 8'h0F, 1, 4'b0001, 2'd0, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000B200, 1, 0, 8'h00, 0, 4'b0000, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000B200, 1, 1, 8'hB2, 0, 4'b0010, 2'd1, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000B300, 1, 1, 8'hB3, 1, 4'b0010, 2'd1, 1));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h00C00000, 1, 0, 8'h00, 0, 4'b0000, 2'd1, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h00C00000, 1, 1, 8'hC0, 0, 4'b0100, 2'd2, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000000F, 1, 0, 8'h00, 0, 4'b0100, 2'd2, 1));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 32'h00C1000F, 1, 1, 8'hC1, 1, 4'b0100, 2'd2, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000000F, 1, 0, 8'h00, 0, 4'b0000, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000000F, 1, 1, 8'h0F, 1, 4'b0001, 2'd0, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0000, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0000, 2'd0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'hD0000000, 1, 0, 8'h00, 0, 4'b0000, 2'd0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'hD0000000, 1, 1, 8'hD0, 0, 4'b1000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'hD1000000, 0, 1, 8'hD1, 0, 4'b0000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'hD1000000, 1, 1, 8'hD1, 0, 4'b1000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'hD2000000, 0, 1, 8'hD2, 0, 4'b0000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'hD2000000, 1, 1, 8'hD2, 0, 4'b1000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 32'hD3000000, 0, 1, 8'hD3, 1, 4'b0000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 32'hD3000000, 1, 1, 8'hD3, 1, 4'b1000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0000, 2'd3, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            async_rst  = tbl[i].rst;
            in_tvalid  = tbl[i].v;
            in_tlast   = tbl[i].l;
            in_tdata   = tbl[i].d;
            in_tuser   = '0;
            out_tready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl[%0d] out_tvalid", i), 64'(out_tvalid), 64'(tbl[i].ov));
            chk($sformatf("tbl[%0d] in_tready", i), 64'(in_tready), 64'(tbl[i].rdy));
            chk($sformatf("tbl[%0d] grant_index", i), 64'(grant_index), 64'(tbl[i].g));
            chk($sformatf("tbl[%0d] busy", i), 64'(busy), 64'(tbl[i].bsy));
            if (tbl[i].ov) begin
                chk($sformatf("tbl[%0d] out_tdata", i), 64'(out_tdata), 64'(tbl[i].od));
                chk($sformatf("tbl[%0d] out_tlast", i), 64'(out_tlast), 64'(tbl[i].ol));
            end
        end
    endtask

    // Every port always holds a 1-beat packet: grants rotate 0,1,2,3,0 with
    // an IDLE bubble in front of each.
    task automatic run_all_request();
        do_reset();
        in_tvalid  = 4'b1111;
        in_tlast   = 4'b1111;
        in_tuser   = 4'b0000;
        in_tdata   = 32'h43424140;
        out_tready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                chk($sformatf("rr c%0d busy", c), 64'(busy), 64'd1);
                chk($sformatf("rr c%0d grant", c), 64'(grant_index), 64'(((c - 1) / 2) % 4));
                chk($sformatf("rr c%0d data", c), 64'(out_tdata), 64'(8'h40 + ((c - 1) / 2) % 4));
            end else begin
                chk($sformatf("rr c%0d busy", c), 64'(busy), 64'd0);
                chk($sformatf("rr c%0d tready", c), 64'(in_tready), 64'd0);
            end
`ifdef AXIS_ARB_PKT_CNT_EN
            if (c == 8)
                chk("rr pkt_count after 4", 64'(pkt_count), 64'h0001_0001_0001_0001);
`endif
        end
        @(posedge clk);
        #1;
        in_tvalid = '0;
`ifdef AXIS_ARB_PKT_CNT_EN
        chk("rr pkt_count after 5", 64'(pkt_count), 64'h0001_0001_0001_0002);
`endif
    endtask

    // Randomized traffic against a packet-level model: each port owns a queue
    // of packets; the model tracks which port owns the output between a grant
    // and that packet's last accepted beat.
    task automatic run_random();
        logic       hold[PORTS];
        logic [7:0] dd[PORTS];
        logic       vv[PORTS];
        logic       ll[PORTS];
        logic       uu[PORTS];
        int         cnt[PORTS];
        int         owner;
        bit         in_pkt;
        bit         done;
        int         cyc;
        int         left;
        int         len;
        beat_t      b;
        logic       ordy;
        logic [3:0] vmask;

        do_reset();
        owner  = PORTS - 1;
        in_pkt = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            hold[p] = 1'b0;
            cnt[p]  = 0;
            for (int k = 0; k < 6; k++) begin
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) begin
                    b.d = 8'($urandom);
                    b.l = (j == len - 1);
                    b.u = 1'($urandom_range(0, 1));
                    q[p].push_back(b);
                end
            end
        end

        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 4000) begin
            left = 0;
            for (int p = 0; p < PORTS; p++) left += q[p].size();
            if (left == 0 && !in_pkt) begin
                done = 1'b1;
            end else begin
                vmask = '0;
                for (int p = 0; p < PORTS; p++) begin
                    if (q[p].size() > 0 && (hold[p] || $urandom_range(0, 3) != 0)) begin
                        vv[p] = 1'b1; dd[p] = q[p][0].d; ll[p] = q[p][0].l; uu[p] = q[p][0].u;
                        hold[p] = 1'b1;
                    end else begin
                        vv[p] = 1'b0; dd[p] = 8'($urandom);
                        ll[p] = 1'($urandom_range(0, 1)); uu[p] = 1'($urandom_range(0, 1));
                    end
                    vmask[p] = vv[p];
                    in_tdata[p*DW +: DW] = dd[p];
                    in_tvalid[p] = vv[p];
                    in_tlast[p]  = ll[p];
                    in_tuser[p]  = uu[p];
                end
                ordy = ($urandom_range(0, 3) != 0);
                out_tready = ordy;

                @(negedge clk);
                if (in_pkt) begin
                    chk("rnd out_tvalid", 64'(out_tvalid), 64'(vv[owner]));
                    chk("rnd in_tready", 64'(in_tready), 64'(ordy) << owner);
                    chk("rnd busy", 64'(busy), 64'd1);
                    if (vv[owner]) begin
                        chk("rnd out_tdata", 64'(out_tdata), 64'(dd[owner]));
                        chk("rnd out_tlast", 64'(out_tlast), 64'(ll[owner]));
                        chk("rnd out_tuser", 64'(out_tuser), 64'(uu[owner]));
                    end
                end else begin
                    chk("rnd idle out_tvalid", 64'(out_tvalid), 64'd0);
                    chk("rnd idle in_tready", 64'(in_tready), 64'd0);
                    chk("rnd idle busy", 64'(busy), 64'd0);
                end
                chk("rnd grant_index", 64'(grant_index), 64'(owner));

                if (in_pkt) begin
                    if (vv[owner] && ordy) begin
                        void'(q[owner].pop_front());
                        hold[owner] = 1'b0;
                        if (ll[owner]) begin
                            in_pkt = 1'b0;
                            cnt[owner]++;
                        end
                    end
                end else if (vmask != 0) begin
                    for (int k = 1; k <= PORTS && !in_pkt; k++) begin
                        if (vv[(owner + k) % PORTS]) begin
                            owner  = (owner + k) % PORTS;
                            in_pkt = 1'b1;
                        end
                    end
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!done) begin
            chk("rnd cycle budget", 64'd1, 64'd0);
        end
        left = 0;
        for (int p = 0; p < PORTS; p++) left += q[p].size();
        chk("rnd beats undelivered", 64'(left), 64'd0);
`ifdef AXIS_ARB_PKT_CNT_EN
        for (int p = 0; p < PORTS; p++)
            chk($sformatf("rnd pkt_count[%0d]", p), 64'(pkt_count[p*16 +: 16]), 64'(cnt[p]));
`endif
        in_tvalid = '0;
    endtask

    initial begin
        async_rst  = 1'b1;
        in_tvalid  = '0;
        in_tlast   = '0;
        in_tuser   = '0;
        in_tdata   = '0;
        out_tready = 1'b1;
        run_table();
        run_all_request();
        run_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
